// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by the write-side (fifo_wptr_full) and
// read-side (fifo_rptr_empty) pointer blocks of the async FIFO.
//   FIFO_WIDTH / DEPTH : default address width and the matching FIFO depth.
//   PTR_MAX_W          : width the pointer helpers work in. A caller
//                        zero-extends its WIDTH+1 pointer to PTR_MAX_W bits
//                        and casts the result back down.
//   bin2gray/gray2bin  : pointer code conversions. Zero upper bits do not
//                        change the low bits of either conversion, so one
//                        helper serves every pointer width.
package fifo_pkg;

  localparam int FIFO_WIDTH = 4;
  localparam int DEPTH      = 2 ** FIFO_WIDTH;
  localparam int PTR_MAX_W  = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-domain pointer and status generator for the async FIFO.
// The block keeps a binary write pointer. It also produces the Gray pointer
// that the read domain synchronizes. From the read pointer, after it has been
// synchronized into this domain, it derives the full, almost-full, fill-level
// and overflow flags.
// Ports:
//   clk         : write-domain clock
//   rst_n       : asynchronous active-low reset
//   winc        : write request; a push happens when winc=1 and full=0
//   wq2_rptr    : Gray read pointer, already synchronized into clk
//   waddr       : RAM write address (low bits of the current binary pointer)
//   wptr        : registered Gray write pointer, sent to the read domain
//   full        : registered FIFO-full flag
//   almost_full : registered; free entries <= AF_MARGIN
//   wlevel      : registered occupancy as seen from this domain, 0..2**WIDTH
//   overflow    : registered one-cycle pulse; winc was asserted while full
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int AF_MARGIN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [WIDTH:0]   wq2_rptr,
  output logic [WIDTH-1:0] waddr,
  output logic [WIDTH:0]   wptr,
  output logic             full,
  output logic             almost_full,
  output logic [WIDTH:0]   wlevel,
  output logic             overflow
);

  // Occupancy at or above this value means free entries <= AF_MARGIN.
  localparam logic [WIDTH:0] AF_THRESH = (WIDTH+1)'((2 ** WIDTH) - AF_MARGIN);

  logic [WIDTH:0] wbin;
  logic           push;
  logic [WIDTH:0] wbin_next;
  logic [WIDTH:0] wgray_next;
  logic [WIDTH:0] rbin_s;
  logic [WIDTH:0] level_next;
  logic [WIDTH:0] full_ptr;

  always_comb begin
    push       = winc & ~full;
    // All pointer arithmetic is modulo 2**(WIDTH+1). The wrap from all-ones
    // to zero therefore needs no special case for full or level.
    wbin_next  = wbin + (WIDTH+1)'(push);
    wgray_next = (WIDTH+1)'(bin2gray(PTR_MAX_W'(wbin_next)));
    rbin_s     = (WIDTH+1)'(gray2bin(PTR_MAX_W'(wq2_rptr)));
    level_next = wbin_next - rbin_s;
    // The FIFO is full when the write pointer is one lap ahead of the read
    // pointer. In Gray code that means the two MSBs differ and the rest match.
    full_ptr   = {~wq2_rptr[WIDTH:WIDTH-1], wq2_rptr[WIDTH-2:0]};
  end

  // waddr comes from the current pointer. The RAM writes at this address in
  // the same cycle as the push, and the address advances on the next cycle.
  assign waddr = wbin[WIDTH-1:0];

  // Registered state: the pointers and all status flags update on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin        <= '0;
      wptr        <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wlevel      <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wptr        <= wgray_next;
      full        <= (wgray_next == full_ptr);
      almost_full <= (level_next >= AF_THRESH);
      wlevel      <= level_next;
      overflow    <= winc & full;
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
module tb_fifo_wptr_full;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       winc  = 1'b0;
  logic [4:0] wq2_rptr = '0;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       full;
  logic       almost_full;
  logic [4:0] wlevel;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;

  // Gray codes of binary 1..16 for a 5-bit pointer, worked out by hand.
  logic [4:0] gtab [16] = '{5'b00001, 5'b00011, 5'b00010, 5'b00110,
                            5'b00111, 5'b00101, 5'b00100, 5'b01100,
                            5'b01101, 5'b01111, 5'b01110, 5'b01010,
                            5'b01011, 5'b01001, 5'b01000, 5'b11000};

  fifo_wptr_full #(.WIDTH(4), .AF_MARGIN(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .winc        (winc),
    .wq2_rptr    (wq2_rptr),
    .waddr       (waddr),
    .wptr        (wptr),
    .full        (full),
    .almost_full (almost_full),
    .wlevel      (wlevel),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".waddr"}, 32'(waddr), 0);
    chk({tag, ".wptr"}, 32'(wptr), 0);
    chk({tag, ".full"}, 32'(full), 0);
    chk({tag, ".af"}, 32'(almost_full), 0);
    chk({tag, ".wlevel"}, 32'(wlevel), 0);
    chk({tag, ".ovf"}, 32'(overflow), 0);
  endtask

  // Reference model used by the wrap test. Here full is taken from the
  // occupancy count, not from a Gray comparison.
  int m_wbin, m_rbin, m_lvl;
  logic m_full, m_ovf, m_push;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk_all_zero("reset");

    // Sixteen pushes with the read pointer held at zero.
    winc = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fill%0d.waddr", i), 32'(waddr), 32'(i));
      step();
      chk($sformatf("fill%0d.wptr", i), 32'(wptr), 32'(gtab[i]));
      chk($sformatf("fill%0d.wlevel", i), 32'(wlevel), 32'(i + 1));
      chk($sformatf("fill%0d.af", i), 32'(almost_full), 32'((i + 1) >= 14));
      chk($sformatf("fill%0d.full", i), 32'(full), 32'((i + 1) == 16));
      chk($sformatf("fill%0d.ovf", i), 32'(overflow), 0);
    end

    // Keep winc asserted while the FIFO is full: the pointer must not move.
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold%0d.ovf", i), 32'(overflow), 1);
      chk($sformatf("hold%0d.wlevel", i), 32'(wlevel), 16);
      chk($sformatf("hold%0d.waddr", i), 32'(waddr), 0);
      chk($sformatf("hold%0d.wptr", i), 32'(wptr), 32'h18);
      chk($sformatf("hold%0d.full", i), 32'(full), 1);
    end

    // One read arrives, then one push fills the FIFO again.
    winc = 1'b0;
    wq2_rptr = 5'b00001;
    step();
    chk("rd1.full", 32'(full), 0);
    chk("rd1.wlevel", 32'(wlevel), 15);
    chk("rd1.af", 32'(almost_full), 1);
    chk("rd1.ovf", 32'(overflow), 0);
    winc = 1'b1;
    step();
    chk("refill.full", 32'(full), 1);
    chk("refill.wlevel", 32'(wlevel), 16);
    chk("refill.wptr", 32'(wptr), 32'h19);
    chk("refill.waddr", 32'(waddr), 1);

    // Wrap test: keep pushing while the read pointer advances, so that wbin
    // wraps past 31.
    m_wbin = 17; m_rbin = 1; m_full = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i % 4 != 3) m_rbin = (m_rbin + 1) % 32;
      wq2_rptr = 5'(m_rbin ^ (m_rbin >> 1));
      winc = 1'b1;
      m_push = ~m_full;
      m_ovf  = m_full;
      m_wbin = (m_wbin + int'(m_push)) % 32;
      m_lvl  = (m_wbin - m_rbin + 32) % 32;
      m_full = (m_lvl == 16);
      step();
      chk($sformatf("wrap%0d.full", i), 32'(full), 32'(m_full));
      chk($sformatf("wrap%0d.wlevel", i), 32'(wlevel), 32'(m_lvl));
      chk($sformatf("wrap%0d.ovf", i), 32'(overflow), 32'(m_ovf));
      chk($sformatf("wrap%0d.af", i), 32'(almost_full), 32'(m_lvl >= 14));
      chk($sformatf("wrap%0d.waddr", i), 32'(waddr), 32'(m_wbin % 16));
    end

    // Assert reset part-way through a burst, between clock edges.
    winc = 1'b0;
    rst_n = 1'b0;
    step();
    wq2_rptr = '0;
    rst_n = 1'b1;
    step();
    winc = 1'b1;
    repeat (9) step();
    chk("mid.wlevel", 32'(wlevel), 9);
    chk("mid.waddr", 32'(waddr), 9);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    winc = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
Write-domain pointer and status generator for the async FIFO. It produces the binary RAM write address and the Gray-coded write pointer that the FIFO's pointer synchronizer carries into the read domain. It also consumes the read pointer after it has been synchronized into the write domain, and from it derives full, almost-full, fill level and an overflow indication.

Parameters:
WIDTH, 4, address width; FIFO depth = 2**WIDTH; pointers are WIDTH+1 bits; legal range WIDTH >= 2.
AF_MARGIN, 2, almost_full asserts when free entries <= AF_MARGIN; legal range 0 .. 2**WIDTH-1.

Ports:
clk  input  1  write-domain clock.
rst_n  input  1  asynchronous active-low reset.
winc  input  1  write request; a push is accepted when winc=1 and full=0.
wq2_rptr  input  WIDTH+1  Gray read pointer, already two-flop synchronized into clk.
waddr  output  WIDTH  RAM write address; equals wbin[WIDTH-1:0].
wptr  output  WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
full  output  1  registered; FIFO full.
almost_full  output  1  registered; free entries <= AF_MARGIN.
wlevel  output  WIDTH+1  registered occupancy as seen from the write domain, 0 .. 2**WIDTH.
overflow  output  1  registered one-cycle pulse; winc was asserted while full=1.

Behaviour:
- Reset (async assert, sync release by system): wbin=0, wptr=0, full=0, almost_full=0, wlevel=0, overflow=0.
- Internal registered binary pointer wbin[WIDTH:0].
- push = winc & ~full.
- wbin_next = wbin + push, modulo 2**(WIDTH+1). It wraps from all-ones to 0 with no special case.
- wgray_next = (wbin_next >> 1) ^ wbin_next.
- Every clk edge: wbin <= wbin_next; wptr <= wgray_next. wptr changes by at most one bit per cycle.
- waddr is taken from the current wbin (not wbin_next). The RAM writes at waddr in the same cycle push=1, and the address advances on the next cycle.
- Full detection: full <= (wgray_next == {~wq2_rptr[WIDTH:WIDTH-1], wq2_rptr[WIDTH-2:0]}), i.e. the two MSBs are inverted and the rest match.
- Level computation:
  - rbin_s = gray2bin(wq2_rptr).
  - wlevel <= wbin_next - rbin_s, modulo 2**(WIDTH+1).
  - almost_full <= (wbin_next - rbin_s) >= 2**WIDTH - AF_MARGIN.
- overflow <= winc & full. Pointers do not move on an overflow attempt, and no RAM write occurs (RAM write enable = push).
- Latency: a push is visible in wptr/full/wlevel one cycle later. A read is visible only after the read pointer crosses the synchronizer (two or more clk cycles). full and level are therefore pessimistic, never optimistic.
- Simultaneous push and read-pointer advance in one cycle: wlevel is unchanged and full re-evaluates with both values.
- Wrap-around: full and level stay correct across the wbin MSB toggle, because all arithmetic is modulo WIDTH+1 bits.
- wq2_rptr is treated as stable per cycle. No further synchronization is done inside this block.
- Reset mid-operation: all outputs clear immediately. The read side must be reset together with this block; pointer skew after a one-sided reset is outside this block's guarantees.

Decomposition:
- Shared package fifo_pkg holds:
  - function bin2gray(WIDTH+1);
  - function gray2bin(WIDTH+1);
  - localparam DEPTH = 2**WIDTH.
- The same package is used by the read-side counterpart fifo_rptr_empty.
- No sub-module: the block is a flat single always_ff plus combinational next-state logic.

Test Plan:
All scenarios use WIDTH=4, AF_MARGIN=2, wq2_rptr held at 0 unless stated.
- Reset release, winc=0: waddr=0, wptr=0, full=0, almost_full=0, wlevel=0, overflow=0.
- 16 consecutive pushes: waddr counts 0..15; wptr follows Gray 00001, 00011, 00010 ...; almost_full rises with the 14th push (wlevel=14); full rises after the 16th push with wptr=11000 and wlevel=16.
- winc held while full: wbin frozen, overflow=1 on every held cycle, wlevel stays 16, no RAM write strobe.
- From full, step wq2_rptr to Gray(1)=00001: next cycle full=0 and wlevel=15; the next push refills and full=1 again.
- Wrap test: push/advance wq2_rptr continuously for 40 entries so wbin wraps past 31→0; full/wlevel must match a reference model every cycle, with no false full at the wrap.
- Assert rst_n low mid-burst with wlevel=9: all outputs go to 0 asynchronously, before the next clk edge.
